microwave_cook_ctrl: RTL and testbench
======================================

Name: microwave_cook_ctrl

Overview:
- Sequencing controller for the microwave countdown datapath.
- Accepts keypad time entry (MM:SS digits), start/stop commands and the door interlock.
- Generates the 1 s tick, counts cook time down, gates the heater and drives the completion beep.
- Feeds binary minute/second values to the existing 7-segment conversion path.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per 1 s tick (benches use 4).
- BEEP_TICKS, 3, number of 1 s ticks the beep stays asserted in DONE.
- MAX_MIN, 99, minute saturation value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- key_valid  in  1  one-cycle strobe, key_digit valid
- key_digit  in  4  keypad digit 0-9; values >9 ignored
- start  in  1  one-cycle start/resume strobe
- stop  in  1  one-cycle stop/pause/clear strobe
- door_open  in  1  door switch level, 1 = open
- min_out  out  8  displayed minutes, binary 0-99
- sec_out  out  8  displayed seconds, binary 0-99 (0-59 after start)
- heater_on  out  1  magnetron enable
- beep  out  1  buzzer enable
- done  out  1  one-cycle pulse on reaching 00:00
- state_out  out  3  current FSM state encoding

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous, active-high.
- Reset values: state IDLE, entry buffer 0000, min/sec 0, prescaler 0, all outputs 0.
- States: IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4. Other codes go to IDLE next cycle.
- Same-cycle event priority: rst > door_open > stop > start > key_valid.
- IDLE:
  - key_valid with a digit ≤9 → ENTRY; buffer = {0,0,0,digit}.
  - start is ignored (see ADD30_EN).
- ENTRY:
  - Each valid key shifts the 4-digit BCD buffer left; a 5th digit drops the oldest.
  - Display: min = 10·D3+D2, sec = 10·D1+D0, registered, one cycle after the key.
  - stop → IDLE, buffer cleared.
  - start with door closed and buffer ≠ 0 → COOK. Load values are normalised: if sec > 59, min+1 and sec−60. Saturate at MAX_MIN:59.
  - start with door open, or with buffer = 0, is ignored.
- COOK:
  - heater_on = (state==COOK) & ~door_open. This is combinational, so the heater drops in the same cycle the door opens.
  - Prescaler clears on COOK entry. The first decrement occurs TICK_DIV cycles after entry.
  - On each tick: if sec > 0, sec−1; else if min > 0, min−1 and sec=59.
  - The tick that produces 00:00 → DONE and pulses done.
  - door_open or stop → PAUSE; prescaler value is frozen.
  - key_valid is ignored.
- PAUSE:
  - Time is held and the heater is off.
  - start with door closed → COOK; prescaler resumes from its frozen value.
  - stop → IDLE; time and buffer cleared.
- DONE:
  - beep=1 for BEEP_TICKS ticks; display holds 00:00; then → IDLE.
  - Any stop, key_valid, start or door_open → IDLE immediately with beep=0.
- rst mid-cook → IDLE next edge; heater_on=0 that cycle.
- No arithmetic wraps: decrement never goes below 00:00, increments saturate.

Optional Feature:
- Macro: MICROWAVE_ADD30_EN.
- Defined:
  - start in COOK adds 30 s (carry into minutes, saturate at MAX_MIN:59) and does not reset the prescaler.
  - start in IDLE, or in ENTRY with buffer = 0 and door closed, begins COOK at 00:30.
- Undefined: those start strobes are ignored.

Decomposition:
- Shared package microwave_pkg contains:
  - state enum (IDLE..DONE, 3-bit);
  - constant SEC_PER_MIN=60;
  - constant ADD_SECS=30;
  - a BCD-digit typedef.
- One sub-module: microwave_tick_gen.
  - Ports: clk, rst, clear, enable; outputs a one-cycle tick every TICK_DIV enabled cycles.
  - Count is held while enable=0.

Test Plan (TICK_DIV=4, BEEP_TICKS=3):
- Keys 1,3,0 then start, door closed:
  - ENTRY shows 01:30.
  - COOK at 01:30; 00:59 after 31 ticks; DONE after 90 ticks (360 cycles).
  - done pulses once; beep high 12 cycles; then IDLE.
- Keys 0,0,7,5 then start → COOK loads 01:15 (normalised); heater_on=1 next cycle.
- COOK at 00:10, door_open raised mid-prescale:
  - heater_on=0 in the same cycle; state PAUSE; time frozen.
  - door closed and start → resumes; the remaining prescale count is preserved.
- Keys 1,2,3,4,5 → display 23:45. stop → IDLE with 00:00. start with an empty buffer → stays IDLE (macro off) or COOK 00:30 (macro on).
- Same cycle start=1 and stop=1 in ENTRY → IDLE. start while door_open=1 in ENTRY → remains ENTRY.
- rst asserted during COOK at 00:05 → next cycle: IDLE, 00:00, heater_on=0, beep=0.

Source files
------------

// File: rtl/microwave_pkg.sv
// ---------------------------------------------------------------------------
// microwave_pkg
// Shared types and constants for the microwave cook controller slice.
//   state_t  : controller state encoding (IDLE..DONE, 3 bits)
//   bcd_t    : one keypad BCD digit
//   bcd2bin  : converts a two-digit BCD pair into a binary value 0-99
// ---------------------------------------------------------------------------
package microwave_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int SEC_PER_MIN = 60;
  localparam int ADD_SECS    = 30;

  typedef logic [3:0] bcd_t;

  // Tens digit times ten is built from shifts (x8 + x2) so no multiplier
  // is needed for the display conversion.
  function automatic logic [7:0] bcd2bin(input bcd_t hi, input bcd_t lo);
    logic [7:0] h;
    h = {4'd0, hi};
    return (h << 3) + (h << 1) + {4'd0, lo};
  endfunction

endpackage

// File: rtl/microwave_tick_gen.sv
// ---------------------------------------------------------------------------
// microwave_tick_gen
// Prescaler producing a one-cycle tick every TICK_DIV enabled clock cycles.
// The count is held while enable is low, so a paused cook resumes from the
// exact point in the current second where it stopped.
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   clear  in  restart the count from zero (wins over enable)
//   enable in  count this cycle
//   tick   out high in the last enabled cycle of each TICK_DIV period
// ---------------------------------------------------------------------------
module microwave_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = enable && w_last;

  // Period counter: wraps to zero on the tick cycle, frozen when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/microwave_cook_ctrl.sv
// ---------------------------------------------------------------------------
// microwave_cook_ctrl
// Sequencing controller for the microwave countdown datapath: keypad MM:SS
// entry, start/stop handling, door interlock, 1 s countdown, heater gating
// and completion beep. Minutes/seconds leave in binary for the 7-segment path.
//   clk, rst            clock and synchronous active-high reset
//   key_valid/key_digit keypad strobe and digit (digits above 9 ignored)
//   start, stop         one-cycle command strobes
//   door_open           door switch level, 1 = open
//   min_out, sec_out    displayed time (binary)
//   heater_on           magnetron enable (drops combinationally on door open)
//   beep                buzzer enable while in DONE
//   done                one-cycle pulse when the countdown reaches 00:00
//   state_out           current state encoding
// Optional feature macro: MICROWAVE_ADD30_EN (start adds 30 s / quick start).
// ---------------------------------------------------------------------------
module microwave_cook_ctrl
  import microwave_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int BEEP_TICKS = 3,
  parameter int MAX_MIN    = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_open,
  output logic [7:0] min_out,
  output logic [7:0] sec_out,
  output logic       heater_on,
  output logic       beep,
  output logic       done,
  output logic [2:0] state_out
);

`ifdef MICROWAVE_ADD30_EN
  localparam bit ADD30_EN = 1'b1;
`else
  localparam bit ADD30_EN = 1'b0;
`endif

  localparam logic [7:0] MAX_MIN_B = 8'(MAX_MIN);
  localparam logic [7:0] SEC_MAX   = 8'(SEC_PER_MIN - 1);
  localparam logic [7:0] SPM_B     = 8'(SEC_PER_MIN);
  localparam logic [7:0] ADD_B     = 8'(ADD_SECS);
  localparam int         BCW       = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
  localparam logic [BCW-1:0] BEEP_LAST = BCW'(BEEP_TICKS - 1);

  state_t         r_state;
  bcd_t [3:0]     r_buf;
  logic [7:0]     r_min;
  logic [7:0]     r_sec;
  logic [BCW-1:0] r_beepCnt;
  logic           r_done;

  state_t         w_nextState;
  bcd_t [3:0]     w_nextBuf;
  bcd_t [3:0]     w_shiftBuf;
  logic [7:0]     w_nextMin, w_nextSec;
  logic [BCW-1:0] w_nextBeepCnt;
  logic           w_doneSet;
  logic           w_keyOk, w_bufZero;
  logic [7:0]     w_loadMin, w_loadSec, w_normMin, w_normSec;
  logic [7:0]     w_stepMin, w_stepSec, w_addMin, w_addSec;
  logic [7:0]     w_finMin, w_finSec;
  logic           w_tick, w_enable, w_clear;

  assign w_keyOk    = key_valid && (key_digit <= 4'd9);
  assign w_bufZero  = (r_buf == '0);
  assign w_shiftBuf = {r_buf[2:0], key_digit};
  assign w_loadMin  = bcd2bin(r_buf[3], r_buf[2]);
  assign w_loadSec  = bcd2bin(r_buf[1], r_buf[0]);

  // The prescaler only runs while actually cooking or beeping; in COOK the
  // cycle that sees door/stop is excluded so the count freezes on that value.
  assign w_enable = ((r_state == S_COOK) && !door_open && !stop) ||
                    (r_state == S_DONE);

  // Every state change restarts the second, except the COOK<->PAUSE pair,
  // which must keep the partial second across a pause.
  assign w_clear = (w_nextState != r_state) &&
                   !((r_state == S_PAUSE) && (w_nextState == S_COOK)) &&
                   !((r_state == S_COOK)  && (w_nextState == S_PAUSE));

  microwave_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clear),
    .enable (w_enable),
    .tick   (w_tick)
  );

  // Time arithmetic: normalise the keyed value for loading, decrement on a
  // tick without going below 00:00, and add 30 s with carry and saturation.
  // The add is applied after the decrement so a tick is never lost.
  always_comb begin
    w_normMin = w_loadMin;
    w_normSec = w_loadSec;
    if (w_loadSec > SEC_MAX) begin
      w_normMin = w_loadMin + 8'd1;
      w_normSec = w_loadSec - SPM_B;
    end
    if (w_normMin > MAX_MIN_B) begin
      w_normMin = MAX_MIN_B;
      w_normSec = SEC_MAX;
    end

    w_stepMin = r_min;
    w_stepSec = r_sec;
    if (w_tick) begin
      if (r_sec != 8'd0) begin
        w_stepSec = r_sec - 8'd1;
      end else if (r_min != 8'd0) begin
        w_stepMin = r_min - 8'd1;
        w_stepSec = SEC_MAX;
      end
    end

    w_addMin = w_stepMin;
    w_addSec = w_stepSec + ADD_B;
    if (w_addSec >= SPM_B) begin
      w_addMin = w_stepMin + 8'd1;
      w_addSec = w_addSec - SPM_B;
    end
    if (w_addMin > MAX_MIN_B) begin
      w_addMin = MAX_MIN_B;
      w_addSec = SEC_MAX;
    end

    w_finMin = (ADD30_EN && start) ? w_addMin : w_stepMin;
    w_finSec = (ADD30_EN && start) ? w_addSec : w_stepSec;
  end

  // Next-state and next-datapath logic. Within each state the branches are
  // ordered door/stop > start > key; an event with no effect in a state does
  // not block lower-priority ones.
  always_comb begin
    w_nextState   = r_state;
    w_nextBuf     = r_buf;
    w_nextMin     = r_min;
    w_nextSec     = r_sec;
    w_nextBeepCnt = r_beepCnt;
    w_doneSet     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!stop) begin
          if (ADD30_EN && start && !door_open) begin
            w_nextState = S_COOK;
            w_nextMin   = 8'd0;
            w_nextSec   = ADD_B;
          end else if (w_keyOk) begin
            w_nextState = S_ENTRY;
            w_nextBuf   = {12'h000, key_digit};
            w_nextMin   = 8'd0;
            w_nextSec   = {4'd0, key_digit};
          end
        end
      end

      S_ENTRY: begin
        if (stop) begin
          w_nextState = S_IDLE;
          w_nextBuf   = '0;
          w_nextMin   = 8'd0;
          w_nextSec   = 8'd0;
        end else if (start && !door_open && !w_bufZero) begin
          w_nextState = S_COOK;
          w_nextMin   = w_normMin;
          w_nextSec   = w_normSec;
        end else if (ADD30_EN && start && !door_open) begin
          w_nextState = S_COOK;
          w_nextMin   = 8'd0;
          w_nextSec   = ADD_B;
        end else if (w_keyOk) begin
          w_nextBuf = w_shiftBuf;
          w_nextMin = bcd2bin(w_shiftBuf[3], w_shiftBuf[2]);
          w_nextSec = bcd2bin(w_shiftBuf[1], w_shiftBuf[0]);
        end
      end

      S_COOK: begin
        if (door_open || stop) begin
          w_nextState = S_PAUSE;
        end else begin
          w_nextMin = w_finMin;
          w_nextSec = w_finSec;
          if ((w_finMin == 8'd0) && (w_finSec == 8'd0)) begin
            w_nextState   = S_DONE;
            w_nextBeepCnt = '0;
            w_doneSet     = 1'b1;
          end
        end
      end

      S_PAUSE: begin
        if (stop) begin
          w_nextState = S_IDLE;
          w_nextBuf   = '0;
          w_nextMin   = 8'd0;
          w_nextSec   = 8'd0;
        end else if (start && !door_open) begin
          w_nextState = S_COOK;
        end
      end

      S_DONE: begin
        if (stop || key_valid || start || door_open) begin
          w_nextState = S_IDLE;
          w_nextBuf   = '0;
          w_nextBeepCnt = '0;
        end else if (w_tick) begin
          if (r_beepCnt == BEEP_LAST) begin
            w_nextState   = S_IDLE;
            w_nextBuf     = '0;
            w_nextBeepCnt = '0;
          end else begin
            w_nextBeepCnt = r_beepCnt + BCW'(1);
          end
        end
      end

      default: begin
        w_nextState   = S_IDLE;
        w_nextBuf     = '0;
        w_nextMin     = 8'd0;
        w_nextSec     = 8'd0;
        w_nextBeepCnt = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_buf     <= '0;
      r_min     <= 8'd0;
      r_sec     <= 8'd0;
      r_beepCnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_buf     <= w_nextBuf;
      r_min     <= w_nextMin;
      r_sec     <= w_nextSec;
      r_beepCnt <= w_nextBeepCnt;
      r_done    <= w_doneSet;
    end
  end

  // Heater and beep are combinational so the door interlock, reset and the
  // DONE cancel events take effect in the very cycle they occur.
  assign heater_on = (r_state == S_COOK) && !door_open && !rst;
  assign beep      = (r_state == S_DONE) &&
                     !(stop || key_valid || start || door_open);
  assign done      = r_done;
  assign min_out   = r_min;
  assign sec_out   = r_sec;
  assign state_out = r_state;

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// ---------------------------------------------------------------------------
// tb_microwave_cook_ctrl
// Directed scenarios followed by randomized rounds, every cycle compared
// against a reference model that tracks remaining cook time as a plain
// number of seconds and the keypad buffer as an array of digits.
// ---------------------------------------------------------------------------
module tb_microwave_cook_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int BEEP_TICKS = 3;
  localparam int MAX_MIN    = 99;
  localparam int MAX_TOTAL  = MAX_MIN * 60 + 59;
`ifdef MICROWAVE_ADD30_EN
  localparam bit ADD30 = 1'b1;
`else
  localparam bit ADD30 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, key_valid, start, stop, door_open;
  logic [3:0] key_digit;
  logic [7:0] min_out, sec_out;
  logic       heater_on, beep, done;
  logic [2:0] state_out;

  int nAssert, nFail, beepSeen, doneSeen;
  bit doorLvl;

  // Reference model: state number, keyed digits (index 3 = most significant),
  // remaining seconds, position within the current second, beep seconds.
  int mState, mRem, mPre, mBeep;
  int mDig[4];
  bit mDoneP;

  microwave_cook_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .BEEP_TICKS (BEEP_TICKS),
    .MAX_MIN    (MAX_MIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .start     (start),
    .stop      (stop),
    .door_open (door_open),
    .min_out   (min_out),
    .sec_out   (sec_out),
    .heater_on (heater_on),
    .beep      (beep),
    .done      (done),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void modelIdle();
    mState = 0; mRem = 0; mPre = 0; mBeep = 0;
    for (int i = 0; i < 4; i++) mDig[i] = 0;
  endfunction

  function automatic int dispMin();
    case (mState)
      1:       return 10 * mDig[3] + mDig[2];
      2, 3:    return mRem / 60;
      default: return 0;
    endcase
  endfunction

  function automatic int dispSec();
    case (mState)
      1:       return 10 * mDig[1] + mDig[0];
      2, 3:    return mRem % 60;
      default: return 0;
    endcase
  endfunction

  function automatic void modelStep(bit r, bit d, bit sp, bit st, bit kv, int kd);
    bit tk;
    int total;
    tk = (mPre == TICK_DIV - 1);
    mDoneP = 1'b0;
    if (r) begin
      modelIdle();
      return;
    end
    case (mState)
      0: begin
        if (sp) begin
        end else if (ADD30 && st && !d) begin
          mState = 2; mRem = 30; mPre = 0;
        end else if (kv && kd <= 9) begin
          mState = 1;
          mDig[3] = 0; mDig[2] = 0; mDig[1] = 0; mDig[0] = kd;
        end
      end
      1: begin
        total = (10 * mDig[3] + mDig[2]) * 60 + 10 * mDig[1] + mDig[0];
        if (sp) modelIdle();
        else if (st && !d && total != 0) begin
          mState = 2; mRem = (total > MAX_TOTAL) ? MAX_TOTAL : total; mPre = 0;
        end else if (ADD30 && st && !d) begin
          mState = 2; mRem = 30; mPre = 0;
        end else if (kv && kd <= 9) begin
          mDig[3] = mDig[2]; mDig[2] = mDig[1]; mDig[1] = mDig[0]; mDig[0] = kd;
        end
      end
      2: begin
        if (d || sp) mState = 3;
        else begin
          if (tk) begin mRem = mRem - 1; mPre = 0; end
          else mPre = mPre + 1;
          if (ADD30 && st) mRem = (mRem + 30 > MAX_TOTAL) ? MAX_TOTAL : mRem + 30;
          if (mRem == 0) begin
            mState = 4; mDoneP = 1'b1; mPre = 0; mBeep = 0;
          end
        end
      end
      3: begin
        if (sp) modelIdle();
        else if (st && !d) mState = 2;
      end
      4: begin
        if (sp || kv || st || d) modelIdle();
        else if (tk) begin
          mPre = 0; mBeep = mBeep + 1;
          if (mBeep == BEEP_TICKS) modelIdle();
        end else mPre = mPre + 1;
      end
      default: modelIdle();
    endcase
  endfunction

  task automatic checkOutput();
    chk("state_out", state_out, mState);
    chk("min_out", min_out, dispMin());
    chk("sec_out", sec_out, dispSec());
    chk("done", done, mDoneP);
    if (done === 1'b1) doneSeen++;
  endtask

  // One clock cycle: drive inputs, check the combinational outputs before
  // the edge, advance the model on the edge, then check registered outputs.
  task automatic applyStimulus(input bit r, input bit sp, input bit st,
                               input bit kv, input logic [3:0] kd);
    rst = r; stop = sp; start = st; key_valid = kv; key_digit = kd;
    door_open = doorLvl;
    #1;
    chk("heater_on", heater_on, (mState == 2) && !doorLvl && !r);
    chk("beep", beep, (mState == 4) && !(sp || st || kv || doorLvl));
    if (beep === 1'b1) beepSeen++;
    @(posedge clk);
    modelStep(r, doorLvl, sp, st, kv, int'(kd));
    #1;
    rst = 1'b0; stop = 1'b0; start = 1'b0; key_valid = 1'b0;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 4'd0);
  endtask

  task automatic pressKey(input logic [3:0] d);
    applyStimulus(0, 0, 0, 1, d);
  endtask

  initial begin
    nAssert = 0; nFail = 0; beepSeen = 0; doneSeen = 0;
    doorLvl = 1'b0;
    rst = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; stop = 1'b0; door_open = 1'b0;
    modelIdle();
    mDoneP = 1'b0;

    // Reset state
    applyStimulus(1, 0, 0, 0, 4'd0);
    chk("reset_state", state_out, 0);
    chk("reset_time", {min_out, sec_out}, 0);
    chk("reset_outs", {heater_on, beep, done}, 0);

    // 1,3,0 -> 01:30, full countdown, beep and return to IDLE
    pressKey(4'd1); pressKey(4'd3); pressKey(4'd0);
    chk("entry_state", state_out, 1);
    chk("entry_0130", {min_out, sec_out}, {8'd1, 8'd30});
    beepSeen = 0; doneSeen = 0;
    applyStimulus(0, 0, 1, 0, 4'd0);
    chk("cook_load_0130", {5'd0, state_out, min_out, sec_out}, {8'd2, 8'd1, 8'd30});
    idle(124);
    chk("after31ticks", {min_out, sec_out}, {8'd0, 8'd59});
    idle(236);
    chk("done_at_360", {state_out, done}, {3'd4, 1'b1});
    idle(12);
    chk("back_idle", state_out, 0);
    chk("beep_cycles", beepSeen, 12);
    chk("done_pulses", doneSeen, 1);

    // 0,0,7,5 -> normalised to 01:15, heater on the next cycle
    pressKey(4'd0); pressKey(4'd0); pressKey(4'd7); pressKey(4'd5);
    chk("entry_0075", {min_out, sec_out}, {8'd0, 8'd75});
    applyStimulus(0, 0, 1, 0, 4'd0);
    chk("cook_norm_0115", {min_out, sec_out}, {8'd1, 8'd15});
    chk("heater_after_start", heater_on, 1);
    applyStimulus(0, 1, 0, 0, 4'd0);
    applyStimulus(0, 1, 0, 0, 4'd0);

    // Door opens mid-second at 00:10; partial second survives the pause
    pressKey(4'd1); pressKey(4'd0);
    applyStimulus(0, 0, 1, 0, 4'd0);
    idle(2);
    doorLvl = 1'b1; door_open = 1'b1;
    #1;
    chk("heater_door_same_cycle", heater_on, 0);
    idle(1);
    chk("pause_state", state_out, 3);
    idle(5);
    chk("pause_frozen", {state_out, min_out, sec_out}, {3'd3, 8'd0, 8'd10});
    doorLvl = 1'b0;
    applyStimulus(0, 0, 1, 0, 4'd0);
    chk("resume_state", state_out, 2);
    idle(1);
    chk("resume_hold", sec_out, 10);
    idle(1);
    chk("resume_partial", sec_out, 9);
    applyStimulus(0, 1, 0, 0, 4'd0);
    applyStimulus(0, 1, 0, 0, 4'd0);

    // Five digits drop the oldest; stop clears; empty start
    pressKey(4'd1); pressKey(4'd2); pressKey(4'd3); pressKey(4'd4); pressKey(4'd5);
    chk("entry_2345", {min_out, sec_out}, {8'd23, 8'd45});
    applyStimulus(0, 1, 0, 0, 4'd0);
    chk("stop_idle", {5'd0, state_out, min_out, sec_out}, 0);
    applyStimulus(0, 0, 1, 0, 4'd0);
    if (ADD30) chk("empty_start", {state_out, sec_out}, {3'd2, 8'd30});
    else       chk("empty_start", {state_out, sec_out}, {3'd0, 8'd0});
    applyStimulus(0, 1, 0, 0, 4'd0);
    applyStimulus(0, 1, 0, 0, 4'd0);

    // start+stop together; start with the door open
    pressKey(4'd5);
    applyStimulus(0, 1, 1, 0, 4'd0);
    chk("start_stop_same", state_out, 0);
    pressKey(4'd5);
    doorLvl = 1'b1;
    applyStimulus(0, 0, 1, 0, 4'd0);
    chk("start_door_open", state_out, 1);
    doorLvl = 1'b0;
    applyStimulus(0, 1, 0, 0, 4'd0);

    // Reset in the middle of a cook
    pressKey(4'd5);
    applyStimulus(0, 0, 1, 0, 4'd0);
    idle(2);
    applyStimulus(1, 0, 0, 0, 4'd0);
    chk("rst_mid_cook", {5'd0, state_out, min_out, sec_out}, 0);
    chk("rst_outs", {heater_on, beep}, 0);

    // Randomized rounds: short keyed time then sparse random events
    for (int round = 0; round < 8; round++) begin
      doorLvl = 1'b0;
      applyStimulus(1, 0, 0, 0, 4'd0);
      pressKey(4'($urandom_range(0, 9)));
      pressKey(4'($urandom_range(0, 9)));
      applyStimulus(0, 0, 1, 0, 4'd0);
      for (int c = 0; c < 420; c++) begin
        int rr;
        bit r, sp, st, kv;
        rr = int'($urandom_range(0, 999));
        if (rr < 10) doorLvl = ~doorLvl;
        r  = ($urandom_range(0, 999) < 2);
        sp = ($urandom_range(0, 999) < 5);
        st = ($urandom_range(0, 999) < 12);
        kv = ($urandom_range(0, 999) < 20);
        applyStimulus(r, sp, st, kv, 4'($urandom_range(0, 11)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
